// File: rtl/sig_capture_unit.sv
// sig_capture_unit: watches the data-memory store port, buffers stores to the
// signature address in a first-word-fall-through FIFO drained over valid/ready,
// and ends the run (halt) on a halt-address store or a cycle timeout once the
// FIFO is empty.
module sig_capture_unit #(
   parameter logic [31:0] SIG_ADDR  = 32'h0000_0F00,
   parameter logic [31:0] HALT_ADDR = 32'hCAFE_BEEF,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TIMEOUT   = 500000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            addr,
   input  logic [31:0]            wdata,
   input  logic                   wr,
   output logic                   sig_valid,
   output logic [31:0]            sig_data,
   input  logic                   sig_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   halt,
   output logic                   timed_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TMO_W-1:0]   cyc_q, cyc_d;
   logic               overflow_q, overflow_d;
   logic               halt_q, halt_d;
   logic               timed_out_q, timed_out_d;
   logic               sig_valid_q, sig_valid_d;
   logic [31:0]        sig_data_q, sig_data_d;
   logic [31:0]        mem_q [DEPTH];
   logic [31:0]        mem_d [DEPTH];

   logic               sig_req;
   logic               halt_req;
   logic               full;
   logic               push;
   logic               pop;

   // Next-state: FIFO bookkeeping, run-control FSM and registered output heads
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cyc_d       = cyc_q;
      overflow_d  = overflow_q;
      timed_out_d = timed_out_q;
      mem_d       = mem_q;

      sig_req  = (state_q == ST_RUN) && !wr && (addr == SIG_ADDR);
      halt_req = (state_q == ST_RUN) && !wr && (addr == HALT_ADDR);
      full     = (count_q == CNT_W'(DEPTH));
      pop      = sig_valid_q && sig_ready;
      // A pop on the same edge frees the slot a full FIFO needs
      push     = sig_req && (!full || pop);

      if (sig_req && full && !pop) begin
         overflow_d = 1'b1;
      end

      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
         ST_RUN: begin
            cyc_d = cyc_q + TMO_W'(1);
            // Halt store wins over a coincident timeout
            if (halt_req) begin
               state_d = ST_DRAIN;
            end else if (cyc_q == TMO_W'(TIMEOUT - 1)) begin
               state_d     = ST_DRAIN;
               timed_out_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (count_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      halt_d      = (state_d == ST_DONE);
      sig_valid_d = (count_d != '0) && (state_d != ST_DONE);
      sig_data_d  = sig_valid_d ? mem_d[rd_ptr_d] : 32'h0;
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cyc_q       <= '0;
         overflow_q  <= 1'b0;
         halt_q      <= 1'b0;
         timed_out_q <= 1'b0;
         sig_valid_q <= 1'b0;
         sig_data_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cyc_q       <= cyc_d;
         overflow_q  <= overflow_d;
         halt_q      <= halt_d;
         timed_out_q <= timed_out_d;
         sig_valid_q <= sig_valid_d;
         sig_data_q  <= sig_data_d;
      end
   end

   // FIFO storage; contents are don't-care while pointers say empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign sig_valid = sig_valid_q;
   assign sig_data  = sig_data_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign halt      = halt_q;
   assign timed_out = timed_out_q;

endmodule

// File: tb/tb_sig_capture_unit.sv
// Scoreboard bench for sig_capture_unit: expected captures are queued when a
// store is driven and checked in order whenever the sink pops a word.
module tb_sig_capture_unit;

   localparam logic [31:0] SIG  = 32'h0000_0F00;
   localparam logic [31:0] HLT  = 32'hCAFE_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr;
   logic        sig_valid;
   logic [31:0] sig_data;
   logic        sig_ready;
   logic [4:0]  count;
   logic        overflow;
   logic        halt;
   logic        timed_out;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q [$];

   sig_capture_unit #(
      .SIG_ADDR (SIG),
      .HALT_ADDR(HLT),
      .DEPTH    (16),
      .TIMEOUT  (100)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .wr       (wr),
      .sig_valid(sig_valid),
      .sig_data (sig_data),
      .sig_ready(sig_ready),
      .count    (count),
      .overflow (overflow),
      .halt     (halt),
      .timed_out(timed_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      wr        = 1'b1;
      addr      = 32'h0;
      wdata     = 32'h0;
      sig_ready = 1'b0;
      exp_q.delete();
      step();
      rst = 1'b0;
   endtask

   // One-cycle store; cap says whether the bench expects it to be captured
   task automatic store(input logic [31:0] a, input logic [31:0] d, input bit cap);
      addr  = a;
      wdata = d;
      wr    = 1'b0;
      if (cap) exp_q.push_back(d);
      step();
      wr   = 1'b1;
      addr = 32'h0;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      int n = 0;
      while (count != 5'd0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(count), 32'd0);
      chk({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every pop the DUT performs must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && sig_valid && sig_ready) begin
         if (exp_q.size() == 0) chk("pop_extra", sig_data, 32'hxxxx_xxxx);
         else chk("pop_data", sig_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_valid", 32'(sig_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_tmo", 32'(timed_out), 32'd0);

      // Ignored stores: wr high at SIG_ADDR, wr high at HALT_ADDR, other address
      addr = SIG; wr = 1'b1; wdata = 32'h55; step();
      addr = HLT; wr = 1'b1; step();
      store(32'h0000_0100, 32'h66, 1'b0);
      chk("ign_count", 32'(count), 32'd0);

      // Three stores streamed with ready high, latency one
      sig_ready = 1'b1;
      store(SIG, 32'h11, 1'b1);
      chk("t1_v0", 32'(sig_valid), 32'd1);
      chk("t1_d0", sig_data, 32'h11);
      store(SIG, 32'h22, 1'b1);
      chk("t1_d1", sig_data, 32'h22);
      store(SIG, 32'h33, 1'b1);
      chk("t1_d2", sig_data, 32'h33);
      step();
      chk("t1_count", 32'(count), 32'd0);
      chk("t1_sb", 32'(exp_q.size()), 32'd0);

      // Overflow: 17 stores into a 16-deep FIFO
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         store(SIG, 32'(i), i <= 16);
         if (i == 16) chk("t2_ovf_pre", 32'(overflow), 32'd0);
      end
      chk("t2_count", 32'(count), 32'd16);
      chk("t2_ovf", 32'(overflow), 32'd1);
      sig_ready = 1'b1;
      wait_empty("t2_drain", 40);
      chk("t2_ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO, push and pop together
      do_reset();
      for (int i = 0; i < 16; i++) store(SIG, 32'h100 + 32'(i), 1'b1);
      chk("t3_full", 32'(count), 32'd16);
      sig_ready = 1'b1;
      store(SIG, 32'hAA, 1'b1);
      chk("t3_ovf", 32'(overflow), 32'd0);
      chk("t3_count", 32'(count), 32'd16);
      wait_empty("t3_drain", 40);

      // Halt store, then capture ignored in DRAIN
      do_reset();
      store(SIG, 32'h1, 1'b1);
      store(SIG, 32'h2, 1'b1);
      store(HLT, 32'h0, 1'b0);
      store(SIG, 32'h99, 1'b0);
      chk("t4_count", 32'(count), 32'd2);
      sig_ready = 1'b1;
      wait_empty("t4_drain", 10);
      chk("t4_halt_pre", 32'(halt), 32'd0);
      step();
      chk("t4_halt", 32'(halt), 32'd1);
      chk("t4_tmo", 32'(timed_out), 32'd0);
      store(SIG, 32'h77, 1'b0);
      chk("t4_done_valid", 32'(sig_valid), 32'd0);
      chk("t4_done_count", 32'(count), 32'd0);

      // Timeout after 100 cycles in RUN
      do_reset();
      sig_ready = 1'b1;
      repeat (99) step();
      chk("t5_tmo_pre", 32'(timed_out), 32'd0);
      step();
      chk("t5_tmo", 32'(timed_out), 32'd1);
      chk("t5_halt_pre", 32'(halt), 32'd0);
      step();
      chk("t5_halt", 32'(halt), 32'd1);

      // Reset in the middle of DRAIN
      do_reset();
      store(SIG, 32'h1, 1'b1);
      store(SIG, 32'h2, 1'b1);
      store(HLT, 32'h0, 1'b0);
      step();
      chk("t6_count_pre", 32'(count), 32'd2);
      do_reset();
      chk("t6_valid", 32'(sig_valid), 32'd0);
      chk("t6_data", sig_data, 32'h0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_halt", 32'(halt), 32'd0);
      chk("t6_tmo", 32'(timed_out), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'd0);
      store(SIG, 32'h5, 1'b1);
      chk("t6_cap_valid", 32'(sig_valid), 32'd1);
      chk("t6_cap_data", sig_data, 32'h5);
      sig_ready = 1'b1;
      wait_empty("t6_drain", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sig_capture_unit.md
Name: sig_capture_unit

Overview:
- Memory-mapped signature and halt monitor on the core's data-memory store port, sitting beside the data memory and consuming the same address, store-data and write-strobe signals.
- Stores to the signature address are buffered in a FIFO and drained over a valid/ready stream to a dump sink.
- A store to the halt address, or a cycle timeout, ends the run once the FIFO has drained, replacing bench-side snooping with synthesizable RTL.

Parameters:
- SIG_ADDR, 32'h00000F00: store address whose data is captured.
- HALT_ADDR, 32'hCAFEBEEF: store address that requests end of run.
- DEPTH, 16: FIFO entries; power of 2, at least 2.
- TIMEOUT, 500000: cycles in RUN before a forced end of run.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- addr, input, 32: memory-stage ALU result (store address).
- wdata, input, 32: store data.
- wr, input, 1: data-memory write strobe, active-low (0 = store this cycle).
- sig_valid, output, 1: FIFO head is valid.
- sig_data, output, 32: FIFO head word.
- sig_ready, input, 1: sink accepts the head this cycle.
- count, output, $clog2(DEPTH)+1: current FIFO occupancy.
- overflow, output, 1: sticky; a capture was dropped.
- halt, output, 1: sticky; run complete and FIFO empty.
- timed_out, output, 1: sticky; the run ended by timeout.

Behaviour:
- Synchronous reset: every output goes to 0; FIFO pointers, count and cycle counter clear; state = RUN. Reset mid-drain discards all buffered entries.
- Reset is sampled every cycle and has priority over all other events.
- Capture: in RUN, when wr==0 and addr==SIG_ADDR, wdata is pushed.
  - The word is visible on sig_data with sig_valid=1 on the next cycle (latency 1).
- Pop: a pop occurs when sig_valid && sig_ready. sig_data is driven from registers, first-word-fall-through, with no combinational path from addr, wdata or wr.
- Simultaneous push and pop:
  - When not empty, both happen and count is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pushed word appears the next cycle and no pop occurs.
- Full with push and no pop: the word is dropped, overflow is set (sticky until reset) and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. count ranges over 0..DEPTH.
- State machine: RUN -> DRAIN -> DONE.
  - RUN: the cycle counter increments each cycle.
    - A store with addr==HALT_ADDR and wr==0 moves to DRAIN on the next cycle.
    - If the counter reaches TIMEOUT-1 with no halt store, move to DRAIN and set timed_out.
    - If a halt store and the timeout occur on the same cycle, the halt wins and timed_out stays 0.
  - DRAIN: captures are ignored (no push, no overflow); pops continue. When count==0, move to DONE.
    - If the FIFO is already empty on entry, DONE is reached on the following cycle.
  - DONE: halt=1; captures are ignored and sig_valid=0. Only rst leaves DONE.
- A store whose address matches neither parameter is ignored.
- wr==1 never triggers a capture or a halt, regardless of addr.
- When a store to SIG_ADDR and the transition to DRAIN coincide, it cannot be the same store (different addresses). The capture applies because the state is still RUN in that cycle.

Test Plan:
- Reset then three stores to 0xF00 with wdata 0x11, 0x22, 0x33, sig_ready=1 -> sig_data shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its store; count returns to 0.
- sig_ready=0 and 17 stores to 0xF00 of 1..17, DEPTH=16 -> count=16; overflow=1 after the 17th store; draining yields 1..16 in order.
- FIFO full and sig_ready=1 while storing 0xAA on the same cycle -> no overflow, count stays 16, 0xAA is eventually popped last.
- Two words buffered and sig_ready=0, then a store to 0xCAFEBEEF, then a store to 0xF00 of 0x99, then sig_ready=1 -> 0x99 is never output; halt=1 one cycle after the last pop; timed_out=0.
- TIMEOUT=100, no halt store -> timed_out=1 and DRAIN entered at cycle 99 after reset; halt=1 once empty.
- In DRAIN with count=2, assert rst for 1 cycle -> all outputs 0 the next cycle and state RUN; a following store to 0xF00 of 0x5 is captured normally.
